alu_writeback: RTL and testbench

- Execute-to-register-file writeback stage directly downstream of the 16-bit ALU.
- Captures the ALU's lower result r, upper result s (MUL high half / DIV remainder), exc_alu flag and function code, then drives the single register-file write port.
- MUL and DIV need two writes: r to the destination register, then s to the fixed high register. A small FSM sequences these writes through the one port.
- Any ALU exception is converted into a held, acknowledged exception report, and the write is suppressed.

---
 rtl/alu_writeback.sv | 129 ++++++++++++
 tb/tb_alu_writeback.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Writeback stage between the 16-bit ALU and the single register-file write port.
// Sequences the two writes of MUL/DIV results and converts ALU exceptions into a held report.
module alu_writeback #(
  parameter int REG_DATA_WIDTH    = 16,
  parameter int ALU_CONTROL_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 4,
  parameter int HI_REG_ADDR       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [REG_DATA_WIDTH-1:0]    r,
  input  logic [REG_DATA_WIDTH-1:0]    s,
  input  logic                         exc_alu,
  input  logic [ALU_CONTROL_WIDTH-1:0] alu_control,
  input  logic [REG_ADDR_WIDTH-1:0]    dest_addr,
  output logic                         wr_en,
  output logic [REG_ADDR_WIDTH-1:0]    wr_addr,
  output logic [REG_DATA_WIDTH-1:0]    wr_data,
  output logic                         exc_pending,
  output logic [ALU_CONTROL_WIDTH-1:0] exc_code,
  input  logic                         exc_ack,
  output logic                         busy
);

  localparam logic [ALU_CONTROL_WIDTH-1:0] OP_NOP = ALU_CONTROL_WIDTH'(4'b0000);
  localparam logic [ALU_CONTROL_WIDTH-1:0] OP_MUL = ALU_CONTROL_WIDTH'(4'b0001);
  localparam logic [ALU_CONTROL_WIDTH-1:0] OP_DIV = ALU_CONTROL_WIDTH'(4'b0010);
  localparam logic [REG_ADDR_WIDTH-1:0]    HI_ADDR = REG_ADDR_WIDTH'(HI_REG_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    EXC   = 2'd3
  } state_t;

  state_t                         state, state_n;
  logic                           md_q, md_n;
  logic [REG_DATA_WIDTH-1:0]      s_q, s_n;
  logic                           wr_en_n;
  logic [REG_ADDR_WIDTH-1:0]      wr_addr_n;
  logic [REG_DATA_WIDTH-1:0]      wr_data_n;
  logic                           exc_pending_n;
  logic [ALU_CONTROL_WIDTH-1:0]   exc_code_n;
  logic                           accept;
  logic                           in_is_md;

  // Handshake: a result transfers on a cycle where in_valid && in_ready;
  // upstream holds its inputs stable while in_valid is high and in_ready is low.
  assign in_ready = (state == IDLE) || ((state == WR_LO) && !md_q);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign in_is_md = (alu_control == OP_MUL) || (alu_control == OP_DIV);

  always_comb begin
    state_n       = state;
    md_n          = md_q;
    s_n           = s_q;
    wr_en_n       = 1'b0;
    wr_addr_n     = wr_addr;
    wr_data_n     = wr_data;
    exc_pending_n = exc_pending;
    exc_code_n    = exc_code;
    case (state)
      IDLE, WR_LO: begin
        if ((state == WR_LO) && md_q) begin
          state_n   = WR_HI;
          wr_en_n   = 1'b1;
          wr_addr_n = HI_ADDR;
          wr_data_n = s_q;
        end else if (accept) begin
          // The exception flag overrides whatever code came with it.
          if (exc_alu) begin
            state_n       = EXC;
            exc_pending_n = 1'b1;
            exc_code_n    = alu_control;
          end else if (alu_control == OP_NOP) begin
            state_n = IDLE;
          end else begin
            state_n   = WR_LO;
            wr_en_n   = 1'b1;
            wr_addr_n = dest_addr;
            wr_data_n = r;
            md_n      = in_is_md;
            if (in_is_md) s_n = s;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WR_HI: begin
        state_n = IDLE;
        md_n    = 1'b0;
      end
      EXC: begin
        if (exc_ack) begin
          state_n       = IDLE;
          exc_pending_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      md_q        <= 1'b0;
      s_q         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      exc_pending <= 1'b0;
      exc_code    <= '0;
    end else begin
      state       <= state_n;
      md_q        <= md_n;
      s_q         <= s_n;
      wr_en       <= wr_en_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      exc_pending <= exc_pending_n;
      exc_code    <= exc_code_n;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed vectors, expected writes and exception codes
// queued at issue time and checked by an independent monitor.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] r = '0;
  logic [15:0] s = '0;
  logic        exc_alu = 1'b0;
  logic [3:0]  alu_control = '0;
  logic [3:0]  dest_addr = '0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        exc_pending;
  logic [3:0]  exc_code;
  logic        exc_ack = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [19:0] exp_q[$];
  logic [3:0]  exc_q[$];
  logic        exc_prev = 1'b0;

  alu_writeback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r(r), .s(s), .exc_alu(exc_alu), .alu_control(alu_control),
    .dest_addr(dest_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .exc_pending(exc_pending), .exc_code(exc_code), .exc_ack(exc_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected write per wr_en pulse, one code per new exception.
  always @(negedge clk) begin
    if (rst) begin
      exc_prev = 1'b0;
    end else begin
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
        end else begin
          check("write_addr_data", {wr_addr, wr_data}, {12'd0, exp_q.pop_front()});
        end
      end
      if (exc_pending === 1'b1 && !exc_prev) begin
        if (exc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_exception: got code=%0h expected none", exc_code);
        end else begin
          check("exc_code", {28'd0, exc_code}, {28'd0, exc_q.pop_front()});
        end
      end
      exc_prev = exc_pending;
    end
  end

  task automatic send(input logic [3:0] ctrl, input logic [15:0] rv, input logic [15:0] sv,
                      input logic [3:0] dest, input logic ex, input bit push, output int stalls);
    bit acc;
    if (push) begin
      if (ex) exc_q.push_back(ctrl);
      else if (ctrl != 4'b0000) begin
        exp_q.push_back({dest, rv});
        if (ctrl == 4'b0001 || ctrl == 4'b0010) exp_q.push_back({4'd0, sv});
      end
    end
    in_valid = 1'b1; alu_control = ctrl; r = rv; s = sv; dest_addr = dest; exc_alu = ex;
    stalls = 0; acc = 1'b0;
    while (!acc && stalls < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (!acc) stalls++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
    end
    in_valid = 1'b0; exc_alu = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int st;
    // Reset state
    @(negedge clk);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr_data", {12'd0, wr_addr, wr_data}, 32'd0);
    check("rst_exc", {27'd0, exc_pending, exc_code}, 32'd0);
    check("rst_busy_ready", {30'd0, busy, in_ready}, 32'd1);
    @(posedge clk); #1; rst = 1'b0;

    // Single ADD: one-cycle latency, single pulse
    send(4'b1111, 16'h0005, 16'h0, 4'd3, 1'b0, 1'b1, st);
    @(negedge clk);
    check("add_wr_en", {31'd0, wr_en}, 32'd1);
    check("add_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("add_pulse_end", {31'd0, wr_en}, 32'd0);
    check("add_idle", {31'd0, busy}, 32'd0);
    check("add_hold", {12'd0, wr_addr, wr_data}, {12'd0, 4'd3, 16'h0005});
    @(posedge clk); #1;

    // MUL then a held ADD: ready low for two cycles, accepted at N+3
    send(4'b0001, 16'h2000, 16'h0001, 4'd5, 1'b0, 1'b1, st);
    check("mul_stall0", st, 0);
    send(4'b1111, 16'h0077, 16'h0, 4'd6, 1'b0, 1'b1, st);
    check("mul_stalls", st, 2);
    wait_idle();

    // Back-to-back single writes
    send(4'b1111, 16'h0011, 16'h0, 4'd1, 1'b0, 1'b1, st);
    check("b2b_0", st, 0);
    send(4'b1100, 16'h00F0, 16'h0, 4'd2, 1'b0, 1'b1, st);
    check("b2b_1", st, 0);
    send(4'b1110, 16'h1234, 16'h0, 4'd4, 1'b0, 1'b1, st);
    check("b2b_2", st, 0);
    wait_idle();

    // Exception held until acknowledged
    send(4'b1110, 16'hFFFF, 16'h0, 4'd7, 1'b1, 1'b1, st);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("exc_hold", {26'd0, in_ready, exc_pending, exc_code}, {26'd0, 1'b0, 1'b1, 4'b1110});
      check("exc_no_write", {31'd0, wr_en}, 32'd0);
    end
    @(posedge clk); #1; exc_ack = 1'b1;
    @(posedge clk); #1; exc_ack = 1'b0;
    @(negedge clk);
    check("exc_cleared", {30'd0, exc_pending, busy}, 32'd0);
    @(posedge clk); #1;
    send(4'b1101, 16'h0A0A, 16'h0, 4'd8, 1'b0, 1'b1, st);
    check("after_ack_accept", st, 0);
    wait_idle();

    // NOP, then invalid code flagged as exception
    send(4'b0000, 16'hBEEF, 16'h0, 4'd9, 1'b0, 1'b1, st);
    @(negedge clk);
    check("nop", {29'd0, wr_en, exc_pending, busy}, 32'd0);
    @(posedge clk); #1;
    send(4'b0111, 16'h0, 16'h0, 4'd1, 1'b1, 1'b1, st);
    @(negedge clk);
    check("inv_exc", {27'd0, exc_pending, exc_code}, {27'd0, 1'b1, 4'b0111});
    @(posedge clk); #1; exc_ack = 1'b1;
    @(posedge clk); #1; exc_ack = 1'b0;
    wait_idle();

    // MUL into the HI register itself: s lands last
    send(4'b0001, 16'h1111, 16'h2222, 4'd0, 1'b0, 1'b1, st);
    wait_idle();

    // DIV interrupted by reset during WR_LO: no HI write may follow
    send(4'b0010, 16'h0100, 16'h0003, 4'd7, 1'b0, 1'b0, st);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {11'd0, wr_en, wr_addr, wr_data}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_hi_write", {30'd0, wr_en, busy}, 32'd0);
    end

    check("exp_q_drained", exp_q.size(), 0);
    check("exc_q_drained", exc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
